spart_fifo: RTL and testbench

- Parametrised successor SPART: a bus-mapped asynchronous serial transmitter/receiver with configurable frame width.
- Adds TX and RX FIFOs, a readable status register and sticky error flags.
- Sits between the processor I/O bus (iocs/iorw/ioaddr/databus) and the board serial pins (txd/rxd).
- Baud timing comes from an internal programmable divisor at 16x oversampling.

---
 rtl/spart_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_fifo.sv
// spart_fifo: bus-mapped UART with TX/RX FIFOs, sticky error status and a programmable 16x baud divisor.
// Build option: define SPART_PARITY_EN to add one even-parity bit after the data bits of every frame.
module spart_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef logic [DATA_BITS-1:0] data_t;
  typedef logic [AW:0]          ptr_t;

`ifdef SPART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_e;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
`endif

  logic [15:0] div_q, div_d, baud_q, baud_d;
  logic        tick;
  data_t       tx_mem_q [FIFO_DEPTH];
  data_t       tx_mem_d [FIFO_DEPTH];
  data_t       rx_mem_q [FIFO_DEPTH];
  data_t       rx_mem_d [FIFO_DEPTH];
  ptr_t        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  ptr_t        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  data_t       tx_head, rx_head;
  logic        rd_en, wr_en, stat_rd;
  logic [7:0]  rd_data;
  logic        ovr_q, ovr_d, frm_q, frm_d, par_q, par_d;
  logic        ovr_evt, frm_evt, par_evt, rx_good;

  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  data_t       tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  data_t       rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_sample, rx_last;
`ifdef SPART_PARITY_EN
  logic        tx_par_q, tx_par_d, rx_par_q, rx_par_d;
`endif

  assign rd_en    = iocs & iorw;
  assign wr_en    = iocs & ~iorw;
  assign stat_rd  = rd_en && (ioaddr == 2'b01);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign tx_full  = ((tx_wp_q ^ tx_rp_q) == {1'b1, {AW{1'b0}}});
  assign rx_full  = ((rx_wp_q ^ rx_rp_q) == {1'b1, {AW{1'b0}}});
  assign tx_head  = tx_mem_q[tx_rp_q[AW-1:0]];
  assign rx_head  = rx_mem_q[rx_rp_q[AW-1:0]];
  assign rx_pop   = rd_en && (ioaddr == 2'b00) && !rx_empty;
  // A full FIFO still accepts a push when the other side pops in the same cycle.
  assign tx_push  = wr_en && (ioaddr == 2'b00) && (!tx_full || tx_pop);
  assign rx_push  = rx_good && (!rx_full || rx_pop);
  assign ovr_evt  = rx_good && rx_full && !rx_pop;
  assign rda      = !rx_empty;
  assign tbr      = !tx_full;
  assign txd      = txd_q;

  always_comb begin
    rd_data = '0;
    case (ioaddr)
      2'b00:   if (!rx_empty) rd_data[DATA_BITS-1:0] = rx_head;
      2'b01:   rd_data = {3'b000, par_q, frm_q, ovr_q, tbr, rda};
      2'b10:   rd_data = div_q[7:0];
      default: rd_data = div_q[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bz;

  always_comb begin
    div_d = div_q;
    if (wr_en && ioaddr == 2'b10) div_d[7:0]  = databus;
    if (wr_en && ioaddr == 2'b11) div_d[15:8] = databus;
    tick   = (baud_q <= 16'd1);
    baud_d = baud_q - 16'd1;
    if (tick) baud_d = (div_q == '0) ? 16'd1 : div_q;
  end

  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    if (tx_push) begin
      tx_mem_d[tx_wp_q[AW-1:0]] = databus[DATA_BITS-1:0];
      tx_wp_d = tx_wp_q + 1'b1;
    end
    if (tx_pop) tx_rp_d = tx_rp_q + 1'b1;
    if (rx_push) begin
      rx_mem_d[rx_wp_q[AW-1:0]] = rx_shift_q;
      rx_wp_d = rx_wp_q + 1'b1;
    end
    if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;
    // An error event in the same cycle as a status read keeps its flag set.
    ovr_d = ovr_evt | (ovr_q & ~stat_rd);
    frm_d = frm_evt | (frm_q & ~stat_rd);
    par_d = par_evt | (par_q & ~stat_rd);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
`ifdef SPART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tick) begin
      tx_cnt_d = tx_cnt_q + 4'd1;
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
`ifdef SPART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end
        end
        TX_START: if (tx_cnt_q == 4'd15) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
        TX_DATA: if (tx_cnt_q == 4'd15) begin
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
`ifdef SPART_PARITY_EN
            tx_state_d = TX_PARITY;
            txd_d      = tx_par_q;
`else
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
`ifdef SPART_PARITY_EN
        TX_PARITY: if (tx_cnt_q == 4'd15) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end
`endif
        TX_STOP: if (tx_cnt_q == 4'd15) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
`ifdef SPART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
          end
        end
        default: begin
          tx_state_d = TX_IDLE;
          txd_d      = 1'b1;
        end
      endcase
    end
  end

  assign rx_sample = tick && (rx_cnt_q == 4'd7);
  assign rx_last   = tick && (rx_cnt_q == 4'd15);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_good    = 1'b0;
    frm_evt    = 1'b0;
    par_evt    = 1'b0;
`ifdef SPART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    if (tick) rx_cnt_d = rx_cnt_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: begin
        if (rx_sample && rx_s2_q) rx_state_d = RX_IDLE;
        else if (rx_last) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
`ifdef SPART_PARITY_EN
          rx_par_d   = 1'b0;
`endif
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
`ifdef SPART_PARITY_EN
          rx_par_d   = rx_par_q ^ rx_s2_q;
`endif
        end
        if (rx_last) begin
          if (rx_bit_q == 3'(DATA_BITS - 1)) begin
`ifdef SPART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef SPART_PARITY_EN
      RX_PARITY: begin
        if (rx_sample) par_evt = rx_par_q ^ rx_s2_q;
        if (rx_last) rx_state_d = RX_STOP;
      end
`endif
      RX_STOP: if (rx_sample) begin
        if (rx_s2_q) begin
          rx_good    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          frm_evt    = 1'b1;
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= DIV_RESET;
      baud_q     <= DIV_RESET;
      tx_mem_q   <= '{default: '0};
      rx_mem_q   <= '{default: '0};
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      par_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
`ifdef SPART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
`endif
    end else begin
      div_q      <= div_d;
      baud_q     <= baud_d;
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      par_q      <= par_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
`ifdef SPART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_spart_fifo.sv
// Self-checking bench for spart_fifo: bus-level register checks, loopback frames, FIFO fill/overrun and RX error handling.
module tb_spart_fifo;
  localparam int BIT_CLKS = 64;  // divisor 4 x 16 ticks
`ifdef SPART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] databus;
  logic [7:0] bus_drv = 8'h00;
  logic       bus_oe = 1'b0;
  logic       rda, tbr, txd, rxd;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;
  int         checks = 0;
  int         errors = 0;

  assign databus = bus_oe ? bus_drv : 8'bz;
  assign rxd     = loop_en ? txd : rx_drv;
  always #5 clk = ~clk;

  spart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_RESET(16'd325)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  // Serial line image of one frame, LSB first, starting with the start bit at index 0.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic stop);
`ifdef SPART_PARITY_EN
    return {1'b0, stop, ^d, d, 1'b0};
`else
    return {2'b00, stop, d, 1'b0};
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; iocs = 1'b0; bus_oe = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_drv = d; bus_oe = 1'b1;
    @(negedge clk);
    iocs = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a; bus_oe = 1'b0;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] v);
    bus_write(2'b10, v[7:0]);
    bus_write(2'b11, v[15:8]);
  endtask

  task automatic wait_txd_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_bits(input logic [11:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bit ok;
    do_reset();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b exp 1", txd); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rst_rda got %b exp 0", rda); end
    checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL rst_tbr got %b exp 1", tbr); end
    bus_read(2'b01, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL rst_status got %h exp 02", v); end
    bus_read(2'b10, v);
    checks++; if (v !== 8'h45) begin errors++; $display("FAIL rst_div_lo got %h exp 45", v); end
    bus_read(2'b11, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL rst_div_hi got %h exp 01", v); end
    // reset asserted while a frame is on the wire
    set_div(16'd4);
    bus_write(2'b00, 8'h00);
    wait_txd_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_start got timeout exp start bit"); end
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd got %b exp 1", txd); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(2'b01, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL midrst_status got %h exp 02", v); end
    bus_read(2'b10, v);
    checks++; if (v !== 8'h45) begin errors++; $display("FAIL midrst_div_lo got %h exp 45", v); end
    bus_read(2'b11, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL midrst_div_hi got %h exp 01", v); end
  endtask

  task automatic test_registers();
    logic [7:0] v;
    do_reset();
    bus_write(2'b10, 8'h12);
    bus_read(2'b10, v);
    checks++; if (v !== 8'h12) begin errors++; $display("FAIL div_lo_wr got %h exp 12", v); end
    bus_read(2'b11, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL div_hi_kept got %h exp 01", v); end
    bus_write(2'b01, 8'hFF);
    bus_read(2'b01, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL status_wr_ignored got %h exp 02", v); end
    bus_read(2'b00, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL empty_read got %h exp 00", v); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL empty_read_rda got %b exp 0", rda); end
  endtask

  task automatic test_loopback();
    logic [7:0]  v;
    logic [7:0]  q[$];
    logic [11:0] fb;
    int          low_cnt;
    int          n;
    bit          ok;
    do_reset();
    set_div(16'd4);
    loop_en = 1'b1;
    bus_write(2'b00, 8'hA5);
    fb = frame_bits(8'hA5, 1'b1);
    wait_txd_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lb_start got timeout exp start bit"); end
    low_cnt = 1;
    while (low_cnt < 200) begin
      @(negedge clk);
      if (txd !== 1'b0) break;
      low_cnt++;
    end
    checks++; if (low_cnt != BIT_CLKS) begin errors++; $display("FAIL lb_start_len got %0d exp %0d", low_cnt, BIT_CLKS); end
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int j = 1; j < FB; j++) begin
      checks++; if (txd !== fb[j]) begin errors++; $display("FAIL lb_bit%0d got %b exp %b", j, txd, fb[j]); end
      if (j < FB - 1) repeat (BIT_CLKS) @(negedge clk);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rda === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL lb_rda got 0 exp 1"); end
    bus_read(2'b00, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL lb_data got %h exp a5", v); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL lb_rda_after got %b exp 0", rda); end
    // random bytes through the loop
    n = 1 + int'($urandom_range(0, 4));
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      q.push_back(v);
      bus_write(2'b00, v);
    end
    repeat (n * FB * BIT_CLKS + 400) @(negedge clk);
    while (q.size() > 0) begin
      bus_read(2'b00, v);
      checks++; if (v !== q[0]) begin errors++; $display("FAIL lb_rand_data got %h exp %h", v, q[0]); end
      void'(q.pop_front());
    end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL lb_rand_rda got %b exp 0", rda); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  v;
    logic [7:0]  q[$];
    logic [11:0] fb;
    bit          ok;
    do_reset();
    loop_en = 1'b1;
    // all writes land well before the first baud tick, so nothing leaves the FIFO yet
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom);
      if (q.size() < 8) q.push_back(v);
      bus_write(2'b00, v);
      checks++;
      if (tbr !== (q.size() < 8)) begin errors++; $display("FAIL fill_tbr%0d got %b exp %b", i, tbr, q.size() < 8); end
    end
    set_div(16'd4);
    wait_txd_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_start got timeout exp start bit"); end
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      fb = frame_bits(q[k], 1'b1);
      for (int j = 0; j < FB; j++) begin
        checks++;
        if (txd !== fb[j]) begin errors++; $display("FAIL b2b_f%0d_b%0d got %b exp %b", k, j, txd, fb[j]); end
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", txd); end
    bus_read(2'b01, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL b2b_status got %h exp 03", v); end
    for (int k = 0; k < 8; k++) begin
      bus_read(2'b00, v);
      checks++; if (v !== q[k]) begin errors++; $display("FAIL b2b_rx%0d got %h exp %h", k, v, q[k]); end
    end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL b2b_rda got %b exp 0", rda); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] v;
    logic [7:0] q[$];
    do_reset();
    set_div(16'd4);
    repeat (340) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom);
      if (q.size() < 8) q.push_back(v);
      send_bits(frame_bits(v, 1'b1), FB);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    bus_read(2'b01, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL ovr_status got %h exp 07", v); end
    bus_read(2'b01, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL ovr_cleared got %h exp 03", v); end
    for (int k = 0; k < 8; k++) begin
      bus_read(2'b00, v);
      checks++; if (v !== q[k]) begin errors++; $display("FAIL ovr_rx%0d got %h exp %h", k, v, q[k]); end
    end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL ovr_rda got %b exp 0", rda); end
  endtask

  task automatic test_framing();
    logic [7:0] v;
    logic [7:0] d;
    do_reset();
    set_div(16'd4);
    repeat (340) @(negedge clk);
    send_bits(frame_bits(8'($urandom), 1'b0), FB);
    repeat (20) @(negedge clk);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL frm_rda got %b exp 0", rda); end
    bus_read(2'b01, v);
    checks++; if (v !== 8'h0A) begin errors++; $display("FAIL frm_status got %h exp 0a", v); end
    bus_read(2'b01, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL frm_cleared got %h exp 02", v); end
    // three-tick glitch must not start a frame
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (FB * BIT_CLKS + 100) @(negedge clk);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL glitch_rda got %b exp 0", rda); end
    bus_read(2'b01, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL glitch_status got %h exp 02", v); end
    d = 8'($urandom);
    send_bits(frame_bits(d, 1'b1), FB);
    repeat (10) @(negedge clk);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL recover_rda got %b exp 1", rda); end
    bus_read(2'b00, v);
    checks++; if (v !== d) begin errors++; $display("FAIL recover_data got %h exp %h", v, d); end
`ifdef SPART_PARITY_EN
    // 0x03 has even weight, so a parity bit of 1 is wrong but the byte is kept
    send_bits({1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    repeat (10) @(negedge clk);
    bus_read(2'b01, v);
    checks++; if (v !== 8'h13) begin errors++; $display("FAIL par_status got %h exp 13", v); end
    bus_read(2'b00, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL par_data got %h exp 03", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_registers();
    test_loopback();
    test_back_to_back();
    test_rx_overrun();
    test_framing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
